// File: rtl/dpwm_pkg.sv
// Shared DPWM constants: sequencer state encoding, count width, default period
// and the frequency-code-to-maxcount table shared with the period converter.
package dpwm_pkg;

  localparam int CNT_W        = 10;
  localparam int MAXCOUNT_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_SOFTSTOP  = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_t;

  // 50 MHz clock: code 0..3 -> 50, 100, 140, 200 kHz
  localparam logic [3:0][CNT_W-1:0] MAXCOUNT_TBL = {
    10'd250, 10'd357, 10'd500, 10'd1000
  };

endpackage

// File: rtl/ramp_timer.sv
// Period_end prescaler: fires tick on the period_end that completes
// RAMP_PERIODS boundaries while a soft ramp is active.
module ramp_timer #(
  parameter int RAMP_PERIODS = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic period_end,
  input  logic active,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(RAMP_PERIODS - 1);

  logic [7:0] cnt;

  // Combinational so the sequencer can apply the step on the same edge.
  assign tick = active && period_end && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (active && period_end) cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
  end

endmodule

// File: rtl/dpwm_sequencer.sv
// DPWM supervisory sequencer: soft-start, run, soft-stop and latched fault,
// with duty/period updates applied only on PWM period boundaries.
module dpwm_sequencer
  import dpwm_pkg::*;
#(
  parameter int W            = CNT_W,
  parameter int RAMP_STEP    = 1,
  parameter int RAMP_PERIODS = 4,
  parameter int MAXCOUNT_RST = MAXCOUNT_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         stop,
  input  logic         fault,
  input  logic         clear_fault,
  input  logic         period_end,
  input  logic [W-1:0] target_duty,
  input  logic [W-1:0] target_maxcount,
  output logic         en,
  output logic [W-1:0] duty_cmd,
  output logic [W-1:0] maxcount_cmd,
  output logic         soft_active,
  output logic         fault_latched,
  output logic [2:0]   state
);

  seq_state_t  state_q, nxt;
  logic [W-1:0] tgt, duty_up, duty_dn, duty_nxt, mc_nxt;
  logic [W:0]   sum;
  logic         tick, ramping;

  assign tgt     = (target_duty < maxcount_cmd) ? target_duty : maxcount_cmd;
  assign sum     = {1'b0, duty_cmd} + (W+1)'(RAMP_STEP);
  assign duty_up = (sum > {1'b0, tgt}) ? tgt : sum[W-1:0];
  assign duty_dn = (duty_cmd > W'(RAMP_STEP)) ? duty_cmd - W'(RAMP_STEP) : '0;
  assign ramping = (state_q == ST_SOFTSTART) || (state_q == ST_SOFTSTOP);
  assign state   = state_q;

  // Counter clears on any state change, so a boundary on that edge is not counted.
  ramp_timer #(.RAMP_PERIODS(RAMP_PERIODS)) u_ramp_timer (
    .clk        (clk),
    .resetn     (resetn),
    .period_end (period_end),
    .active     (ramping),
    .clr        (nxt != state_q),
    .tick       (tick)
  );

  always_comb begin
    nxt      = state_q;
    duty_nxt = duty_cmd;
    mc_nxt   = maxcount_cmd;
    if (fault) begin
      nxt      = ST_FAULT;
      duty_nxt = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_nxt = '0;
          mc_nxt   = target_maxcount;
          if (!stop && start) nxt = ST_SOFTSTART;
        end
        ST_SOFTSTART: begin
          if (stop) nxt = ST_SOFTSTOP;
          else begin
            if (tick) duty_nxt = duty_up;
            if (period_end && duty_nxt == tgt) nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) nxt = ST_SOFTSTOP;
          else if (period_end) begin
            duty_nxt = tgt;
            mc_nxt   = target_maxcount;
          end
        end
        ST_SOFTSTOP: begin
          if (tick) duty_nxt = duty_dn;
          if (period_end && duty_nxt == '0) nxt = ST_IDLE;
        end
        ST_FAULT: begin
          duty_nxt = '0;
          if (clear_fault) nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      en            <= 1'b0;
      duty_cmd      <= '0;
      maxcount_cmd  <= W'(MAXCOUNT_RST);
      soft_active   <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= nxt;
      en            <= (nxt == ST_SOFTSTART) || (nxt == ST_RUN) || (nxt == ST_SOFTSTOP);
      duty_cmd      <= duty_nxt;
      maxcount_cmd  <= mc_nxt;
      soft_active   <= (nxt == ST_SOFTSTART) || (nxt == ST_SOFTSTOP);
      fault_latched <= (nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Bench for dpwm_sequencer: vector table, directed ramp/fault sequences and
// randomized stimulus against a period-counting reference model.
module tb_dpwm_sequencer;

  localparam int STEP = 10;
  localparam int RP   = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, stop = 1'b0, fault = 1'b0, clear_fault = 1'b0, period_end = 1'b0;
  logic [9:0] target_duty = '0, target_maxcount = '0;
  logic       en, soft_active, fault_latched;
  logic [9:0] duty_cmd, maxcount_cmd;
  logic [2:0] state;

  int tests = 0, fails = 0, mfail = 0;

  always #10 clk = ~clk;

  dpwm_sequencer #(.W(10), .RAMP_STEP(STEP), .RAMP_PERIODS(RP), .MAXCOUNT_RST(1000)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .fault(fault),
    .clear_fault(clear_fault), .period_end(period_end), .target_duty(target_duty),
    .target_maxcount(target_maxcount), .en(en), .duty_cmd(duty_cmd),
    .maxcount_cmd(maxcount_cmd), .soft_active(soft_active),
    .fault_latched(fault_latched), .state(state)
  );

  // Reference model: counts boundaries since state entry; a step lands on
  // every RP-th one. States: 0 idle, 1 ramp up, 2 run, 3 ramp down, 4 fault.
  int m_st, m_duty, m_mc, m_pe;
  always @(posedge clk or negedge resetn) begin
    int tgt, ns, d, mc, pe;
    if (!resetn) begin
      m_st <= 0; m_duty <= 0; m_mc <= 1000; m_pe <= 0;
    end else begin
      d = m_duty; mc = m_mc; pe = m_pe; ns = m_st;
      tgt = (int'(target_duty) < m_mc) ? int'(target_duty) : m_mc;
      if (fault) begin
        ns = 4; d = 0;
      end else if (m_st == 0) begin
        d = 0; mc = int'(target_maxcount);
        if (start && !stop) ns = 1;
      end else if (m_st == 1) begin
        if (stop) ns = 3;
        else if (period_end) begin
          pe++;
          if (pe % RP == 0) d = (d + STEP < tgt) ? d + STEP : tgt;
          if (d == tgt) ns = 2;
        end
      end else if (m_st == 2) begin
        if (stop) ns = 3;
        else if (period_end) begin d = tgt; mc = int'(target_maxcount); end
      end else if (m_st == 3) begin
        if (period_end) begin
          pe++;
          if (pe % RP == 0) d = (d > STEP) ? d - STEP : 0;
          if (d == 0) ns = 0;
        end
      end else if (clear_fault) ns = 0;
      if (ns != m_st) pe = 0;
      m_st <= ns; m_duty <= d; m_mc <= mc; m_pe <= pe;
    end
  end

  function automatic logic [25:0] pack_exp(int st, int d, int mc);
    logic [2:0] s;
    s = 3'(st);
    return {s, (st >= 1 && st <= 3), (st == 1 || st == 3), (st == 4), 10'(d), 10'(mc)};
  endfunction

  function automatic logic [25:0] pack_act();
    return {state, en, soft_active, fault_latched, duty_cmd, maxcount_cmd};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // One clock; then compare the DUT against the model (capped to limit noise).
  task automatic cyc();
    @(posedge clk); #1;
    if (mfail < 10) begin
      tests++;
      if (pack_act() !== pack_exp(m_st, m_duty, m_mc)) begin
        fails++; mfail++;
        $display("FAIL model t=%0t: got st=%0d en=%0b duty=%0d mc=%0d expected st=%0d duty=%0d mc=%0d",
                 $time, state, en, duty_cmd, maxcount_cmd, m_st, m_duty, m_mc);
      end
    end
  endtask

  task automatic period();
    repeat (357) cyc();
    period_end = 1'b1; cyc(); period_end = 1'b0;
  endtask

  typedef struct {
    logic st, sp, ft, cf, pe;
    int td, tm, e_st, e_duty, e_mc;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{0,0,0,0,0, 0,357,   0,0,357};
    vt[1]  = '{1,1,0,0,0, 0,357,   0,0,357};
    vt[2]  = '{0,0,1,0,0, 0,400,   4,0,357};
    vt[3]  = '{0,0,1,1,0, 0,400,   4,0,357};
    vt[4]  = '{0,0,0,1,0, 0,500,   0,0,357};
    vt[5]  = '{0,0,0,0,0, 0,500,   0,0,500};
    vt[6]  = '{1,0,0,0,0, 150,500, 1,0,500};
    vt[7]  = '{0,0,0,0,1, 150,500, 1,0,500};
    vt[8]  = '{0,0,0,0,1, 150,250, 1,10,500};
    vt[9]  = '{0,1,0,0,0, 150,250, 3,10,500};
    vt[10] = '{1,0,0,0,1, 150,250, 3,10,500};
    vt[11] = '{0,0,0,0,1, 150,250, 0,0,500};
    vt[12] = '{0,0,0,0,0, 150,250, 0,0,250};
    vt[13] = '{0,0,0,0,0, 0,1023,  0,0,1023};
    vt[14] = '{1,0,0,0,0, 0,1023,  1,0,1023};
    vt[15] = '{0,0,0,0,1, 0,1023,  2,0,1023};
    vt[16] = '{0,1,0,0,0, 0,1023,  3,0,1023};
    vt[17] = '{0,0,0,0,1, 0,1023,  0,0,1023};

    repeat (3) cyc();
    chk("reset_state", 32'(pack_act()), 32'(pack_exp(0, 0, 1000)));
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start = vt[i].st; stop = vt[i].sp; fault = vt[i].ft; clear_fault = vt[i].cf;
      period_end = vt[i].pe; target_duty = 10'(vt[i].td); target_maxcount = 10'(vt[i].tm);
      cyc();
      chk($sformatf("vec%0d", i), 32'(pack_act()), 32'(pack_exp(vt[i].e_st, vt[i].e_duty, vt[i].e_mc)));
    end
    start = 0; stop = 0; fault = 0; clear_fault = 0; period_end = 0;

    // Soft-start to 150 with a 358-clock period
    target_duty = 10'd150; target_maxcount = 10'd357; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("ss_en", 32'(en), 32'd1);
    chk("ss_state", 32'(state), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      period();
      if (k % 2 == 0) chk($sformatf("ss_duty_pe%0d", k), 32'(duty_cmd), 32'((k / 2) * 10));
      if (k == 29) chk("ss_not_run_yet", 32'(state), 32'd1);
    end
    chk("run_state", 32'(state), 32'd2);
    chk("run_mc", 32'(maxcount_cmd), 32'd357);

    // Target changes apply only at the boundary; clamp to maxcount
    repeat (100) cyc();
    target_duty = 10'd200; cyc();
    chk("run_hold_mid", 32'(duty_cmd), 32'd150);
    period();
    chk("run_upd_200", 32'(duty_cmd), 32'd200);
    target_duty = 10'd400; period();
    chk("run_clamp", 32'(duty_cmd), 32'd357);
    target_duty = 10'd150; period();
    chk("run_back_150", 32'(duty_cmd), 32'd150);

    // Soft-stop from 150
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_entry", 32'({state, duty_cmd}), 32'({3'd3, 10'd150}));
    for (int k = 1; k <= 30; k++) begin
      period();
      if (k % 2 == 0 && k < 30) chk($sformatf("sd_duty_pe%0d", k), 32'(duty_cmd), 32'(150 - (k / 2) * 10));
    end
    chk("sd_idle", 32'({state, en, duty_cmd}), 32'({3'd0, 1'b0, 10'd0}));

    // Fault during soft-start at duty 60
    start = 1'b1; cyc(); start = 1'b0;
    repeat (12) period();
    chk("f_pre_duty", 32'(duty_cmd), 32'd60);
    fault = 1'b1; cyc();
    chk("f_entry", 32'({state, en, fault_latched, duty_cmd}), 32'({3'd4, 1'b0, 1'b1, 10'd0}));
    clear_fault = 1'b1; cyc();
    chk("f_clear_blocked", 32'(state), 32'd4);
    clear_fault = 1'b0; fault = 1'b0; cyc();
    chk("f_held", 32'(state), 32'd4);
    clear_fault = 1'b1; cyc(); clear_fault = 1'b0;
    chk("f_exit", 32'({state, fault_latched}), 32'({3'd0, 1'b0}));

    // Asynchronous reset mid-ramp
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) period();
    chk("ar_pre_duty", 32'(duty_cmd), 32'd20);
    #3 resetn = 1'b0; #1;
    chk("ar_async", 32'(pack_act()), 32'(pack_exp(0, 0, 1000)));
    cyc(); resetn = 1'b1; cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 19) == 0);
      fault       = ($urandom_range(0, 79) == 0);
      clear_fault = ($urandom_range(0, 7) == 0);
      period_end  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 15) == 0) target_duty = 10'($urandom_range(0, 80));
      if ($urandom_range(0, 31) == 0) target_maxcount = 10'($urandom_range(20, 1023));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
